// File: rtl/svt_objection_barrier.sv
// Objection barrier: per-channel raise/drop counters plus a run-phase FSM that
// completes after a quiet drain window. Optional run-phase timeout via SVT_OBJ_TIMEOUT_EN.
module svt_objection_barrier #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 8,
  parameter int DRAIN_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start_i,
  input  logic [NUM_CH-1:0]       raise_i,
  input  logic [NUM_CH-1:0]       drop_i,
  output logic [NUM_CH*CNT_W-1:0] obj_count_o,
  output logic                    obj_any_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    timeout_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN,
    ST_DONE,
    ST_TIMEOUT
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      drain_q, drain_d;
  logic [CNT_W-1:0] count_q [NUM_CH];
  logic [CNT_W-1:0] count_d [NUM_CH];
  logic [NUM_CH-1:0] ch_err;
  logic             err_q;
  logic             to_hit;

  // Simultaneous raise and drop cancel; saturation and underflow hold the count and flag an error.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      count_d[k] = count_q[k];
      ch_err[k]  = 1'b0;
      if (raise_i[k] && !drop_i[k]) begin
        if (&count_q[k]) ch_err[k] = 1'b1;
        else             count_d[k] = count_q[k] + CNT_W'(1);
      end else if (drop_i[k] && !raise_i[k]) begin
        if (count_q[k] == '0) ch_err[k] = 1'b1;
        else                  count_d[k] = count_q[k] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) count_q[k] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) count_q[k] <= count_d[k];
      err_q <= err_q | (|ch_err);
    end
  end

  always_comb begin
    obj_count_o = '0;
    for (int k = 0; k < NUM_CH; k++) obj_count_o[k*CNT_W +: CNT_W] = count_q[k];
  end

  assign obj_any_o = |obj_count_o;
  assign err_o     = err_q;
  assign busy_o    = (state_q == ST_ACTIVE) || (state_q == ST_DRAIN);
  assign done_o    = (state_q == ST_DONE);

`ifdef SVT_OBJ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt_q;

  // Run-phase age: zero on the cycle ACTIVE is entered, then counts every busy cycle.
  always_ff @(posedge clock) begin
    if (!reset_n)                             to_cnt_q <= '0;
    else if (state_q == ST_IDLE && start_i)   to_cnt_q <= '0;
    else if (busy_o)                          to_cnt_q <= to_cnt_q + TO_W'(1);
  end

  assign to_hit    = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o = (state_q == ST_TIMEOUT);
`else
  assign to_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Completion in the last drain cycle takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (to_hit) begin
          state_d = ST_TIMEOUT;
        end else if (!obj_any_o && (raise_i == '0)) begin
          state_d = ST_DRAIN;
          drain_d = 16'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        if ((raise_i == '0) && (drain_q == '0)) begin
          state_d = ST_DONE;
        end else if (to_hit) begin
          state_d = ST_TIMEOUT;
        end else if (raise_i != '0) begin
          state_d = ST_ACTIVE;
        end else begin
          drain_d = drain_q - 16'd1;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      ST_TIMEOUT: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_svt_objection_barrier.sv
// Self-checking bench for svt_objection_barrier: vector table, directed corner
// sequences and randomized traffic against a counting/phase reference model.
module tb_svt_objection_barrier;

  localparam int NUM_CH         = 4;
  localparam int CNT_W          = 4;
  localparam int DRAIN_CYCLES   = 3;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int CNT_MAX        = (1 << CNT_W) - 1;
`ifdef SVT_OBJ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start_i;
  logic [3:0]  raise_i;
  logic [3:0]  drop_i;
  logic [15:0] obj_count_o;
  logic        obj_any_o, busy_o, done_o, err_o, timeout_o;

  int vectors     = 0;
  int miscompares = 0;

  svt_objection_barrier #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start_i(start_i), .raise_i(raise_i), .drop_i(drop_i),
    .obj_count_o(obj_count_o), .obj_any_o(obj_any_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .timeout_o(timeout_o)
  );

  always #5 clock = ~clock;

  // Reference model: clamped integer counts and a run described by its age and quiet-window age.
  int mCnt [NUM_CH];
  bit mErr, mRunning, mDone, mTimeout;
  int mDrainAge, mRunAge;

  task automatic modelStep(input bit rn, input bit st, input logic [3:0] r, input logic [3:0] d);
    int total;
    bit toHit;
    if (!rn) begin
      for (int k = 0; k < NUM_CH; k++) mCnt[k] = 0;
      mErr = 0; mRunning = 0; mDone = 0; mTimeout = 0; mDrainAge = -1; mRunAge = 0;
      return;
    end
    total = 0;
    for (int k = 0; k < NUM_CH; k++) total += mCnt[k];
    if (mDone || mTimeout) begin
      mDone = 0; mTimeout = 0;
    end else if (!mRunning) begin
      if (st) begin mRunning = 1; mRunAge = 0; mDrainAge = -1; end
    end else begin
      toHit = TO_EN && (mRunAge == TIMEOUT_CYCLES - 1);
      if (mDrainAge >= 0) begin
        if (r == 0 && mDrainAge == DRAIN_CYCLES) begin mRunning = 0; mDone = 1; end
        else if (toHit)                          begin mRunning = 0; mTimeout = 1; end
        else if (r != 0)                         mDrainAge = -1;
        else                                     mDrainAge++;
      end else begin
        if (toHit)                       begin mRunning = 0; mTimeout = 1; end
        else if (total == 0 && r == 0)   mDrainAge = 0;
      end
      mRunAge++;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      int n;
      n = mCnt[k] + int'(r[k]) - int'(d[k]);
      if (n > CNT_MAX) begin n = CNT_MAX; mErr = 1; end
      if (n < 0)       begin n = 0;       mErr = 1; end
      mCnt[k] = n;
    end
  endtask

  function automatic logic [15:0] modelCounts();
    logic [15:0] p;
    p = '0;
    for (int k = 0; k < NUM_CH; k++) p[k*CNT_W +: CNT_W] = mCnt[k][CNT_W-1:0];
    return p;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, land on the next falling edge.
  task automatic applyStimulus(input bit rn, input bit st, input logic [3:0] r, input logic [3:0] d);
    reset_n = rn; start_i = st; raise_i = r; drop_i = d;
    @(posedge clock);
    modelStep(rn, st, r, d);
    @(negedge clock);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] c, input logic any,
                             input logic busy, input logic done, input logic err, input logic to);
    vectors++;
    if (obj_count_o !== c) begin miscompares++; $display("[TB] FAIL %s obj_count_o got %h expected %h", name, obj_count_o, c); end
    if (obj_any_o !== any) begin miscompares++; $display("[TB] FAIL %s obj_any_o got %b expected %b", name, obj_any_o, any); end
    if (busy_o !== busy)   begin miscompares++; $display("[TB] FAIL %s busy_o got %b expected %b", name, busy_o, busy); end
    if (done_o !== done)   begin miscompares++; $display("[TB] FAIL %s done_o got %b expected %b", name, done_o, done); end
    if (err_o !== err)     begin miscompares++; $display("[TB] FAIL %s err_o got %b expected %b", name, err_o, err); end
    if (timeout_o !== to)  begin miscompares++; $display("[TB] FAIL %s timeout_o got %b expected %b", name, timeout_o, to); end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, modelCounts(), modelCounts() != 0, mRunning, mDone, mErr, mTimeout);
  endtask

  typedef struct {
    logic        rn;
    logic        st;
    logic [3:0]  r;
    logic [3:0]  d;
    logic [15:0] cnt;
    logic        any;
    logic        busy;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic rn, input logic st, input logic [3:0] r, input logic [3:0] d,
                        input logic [15:0] cnt, input logic any, input logic busy,
                        input logic done, input logic err);
    vec_t v;
    v.rn = rn; v.st = st; v.r = r; v.d = d; v.cnt = cnt;
    v.any = any; v.busy = busy; v.done = done; v.err = err;
    vecs.push_back(v);
  endtask

  initial begin
    reset_n = 1'b0; start_i = 1'b0; raise_i = '0; drop_i = '0;

    // Basic run: each row's expectations are the outputs one cycle after its inputs.
    addVec(0, 0, 4'h0, 4'h0, 16'h0000, 0, 0, 0, 0);
    addVec(1, 0, 4'h1, 4'h0, 16'h0001, 1, 0, 0, 0);
    addVec(1, 1, 4'h0, 4'h0, 16'h0001, 1, 1, 0, 0);
    addVec(1, 0, 4'h0, 4'h0, 16'h0001, 1, 1, 0, 0);
    addVec(1, 0, 4'h0, 4'h0, 16'h0001, 1, 1, 0, 0);
    addVec(1, 0, 4'h0, 4'h0, 16'h0001, 1, 1, 0, 0);
    addVec(1, 0, 4'h0, 4'h1, 16'h0000, 0, 1, 0, 0);
    addVec(1, 0, 4'h0, 4'h0, 16'h0000, 0, 1, 0, 0);
    addVec(1, 0, 4'h0, 4'h0, 16'h0000, 0, 1, 0, 0);
    addVec(1, 0, 4'h0, 4'h0, 16'h0000, 0, 1, 0, 0);
    addVec(1, 0, 4'h0, 4'h0, 16'h0000, 0, 1, 0, 0);
    addVec(1, 0, 4'h0, 4'h0, 16'h0000, 0, 0, 1, 0);
    addVec(1, 0, 4'h0, 4'h0, 16'h0000, 0, 0, 0, 0);
    addVec(1, 1, 4'h0, 4'h0, 16'h0000, 0, 1, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rn, vecs[i].st, vecs[i].r, vecs[i].d);
      checkOutput($sformatf("table[%0d]", i), vecs[i].cnt, vecs[i].any, vecs[i].busy,
                  vecs[i].done, vecs[i].err, 1'b0);
    end

    // Drain interrupted by a new raise, then completion five cycles after the last drop lands.
    applyStimulus(0, 0, 4'h0, 4'h0);
    applyStimulus(1, 1, 4'h0, 4'h0);
    applyStimulus(1, 0, 4'h6, 4'h0); checkModel("restart_raise");
    applyStimulus(1, 0, 4'h2, 4'h0);
    applyStimulus(1, 0, 4'h2, 4'h0); checkOutput("restart_cnt", 16'h0130, 1, 1, 0, 0, 0);
    applyStimulus(1, 0, 4'h0, 4'h6);
    applyStimulus(1, 0, 4'h0, 4'h2);
    applyStimulus(1, 0, 4'h0, 4'h2); checkModel("restart_zero");
    applyStimulus(1, 0, 4'h0, 4'h0);
    applyStimulus(1, 0, 4'h0, 4'h0); checkModel("restart_drain");
    applyStimulus(1, 0, 4'h4, 4'h0); checkOutput("restart_back", 16'h0100, 1, 1, 0, 0, 0);
    applyStimulus(1, 0, 4'h0, 4'h4); checkOutput("restart_drop", 16'h0000, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, 0, 4'h0, 4'h0);
      checkOutput($sformatf("restart_wait%0d", i), 16'h0000, 0, 1, 0, 0, 0);
    end
    applyStimulus(1, 0, 4'h0, 4'h0); checkOutput("restart_done", 16'h0000, 0, 0, 1, 0, 0);

    // Saturation on ch3 and a lone drop at zero on ch0.
    applyStimulus(0, 0, 4'h0, 4'h0);
    for (int i = 0; i < 15; i++) applyStimulus(1, 0, 4'h8, 4'h0);
    checkOutput("sat_15", 16'hF000, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 4'h8, 4'h0); checkOutput("sat_16", 16'hF000, 1, 0, 0, 1, 0);
    applyStimulus(1, 0, 4'h0, 4'h1); checkOutput("underflow", 16'hF000, 1, 0, 0, 1, 0);

    // Simultaneous raise/drop on every channel holds counts and the ACTIVE state.
    applyStimulus(0, 0, 4'h0, 4'h0); checkOutput("reset_clears_err", 16'h0000, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 4'hF, 4'h0);
    applyStimulus(1, 0, 4'hF, 4'h0);
    applyStimulus(1, 1, 4'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 4'hF, 4'hF);
      checkOutput($sformatf("cancel%0d", i), 16'h2222, 1, 1, 0, 0, 0);
    end
    applyStimulus(1, 0, 4'h0, 4'hF); applyStimulus(1, 0, 4'h0, 4'hF);
    applyStimulus(1, 0, 4'h0, 4'h0); checkOutput("cancel_drain", 16'h0000, 0, 1, 0, 0, 0);

    // Reset in the middle of a drain abandons the phase silently.
    applyStimulus(0, 0, 4'h0, 4'h0);
    applyStimulus(1, 1, 4'h0, 4'h0);
    applyStimulus(1, 0, 4'h0, 4'h0);
    applyStimulus(1, 0, 4'h0, 4'h0); checkModel("pre_reset_drain");
    applyStimulus(0, 0, 4'h0, 4'h0); checkOutput("mid_reset", 16'h0000, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 4'h0, 4'h0);
      checkOutput($sformatf("post_reset%0d", i), 16'h0000, 0, 0, 0, 0, 0);
    end

`ifdef SVT_OBJ_TIMEOUT_EN
    // A never-dropped objection must end the phase by timeout, not completion.
    applyStimulus(0, 0, 4'h0, 4'h0);
    applyStimulus(1, 0, 4'h1, 4'h0);
    applyStimulus(1, 1, 4'h0, 4'h0);
    for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
      applyStimulus(1, 0, 4'h0, 4'h0);
      checkOutput($sformatf("to_wait%0d", i), 16'h0001, 1, 1, 0, 0, 0);
    end
    applyStimulus(1, 0, 4'h0, 4'h0); checkOutput("to_pulse", 16'h0001, 1, 0, 0, 0, 1);
    applyStimulus(1, 0, 4'h0, 4'h0); checkOutput("to_idle", 16'h0001, 1, 0, 0, 0, 0);
`endif

    // Randomized traffic with alternating quiet and raise-heavy stretches.
    applyStimulus(0, 0, 4'h0, 4'h0);
    for (int i = 0; i < 3000; i++) begin
      bit rn, st;
      logic [3:0] r, d;
      bit heavy;
      heavy = ((i / 300) % 2) == 1;
      rn = ($urandom_range(99) != 0);
      st = ($urandom_range(3) == 0);
      for (int k = 0; k < NUM_CH; k++) begin
        r[k] = heavy ? ($urandom_range(1) == 0) : ($urandom_range(9) == 0);
        d[k] = ($urandom_range(3) == 0);
      end
      applyStimulus(rn, st, r, d);
      checkModel($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
